// File: rtl/logic_axi4_stream_timer_pkg.sv
// rtl/logic_axi4_stream_timer_pkg.sv - shared types and constants for the stream countdown timer
package logic_axi4_stream_timer_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        PENDING = 2'd2
    } timer_state_e;

    localparam int OVERRUN_BIT = 0;

endpackage

// File: rtl/logic_axi4_stream_if.sv
// rtl/logic_axi4_stream_if.sv - AXI4-Stream bundle with receiver and transmitter views
interface logic_axi4_stream_if #(
    parameter int TDATA_BYTES = 4,
    parameter int TUSER_W     = 1,
    parameter int TDEST_W     = 1,
    parameter int TID_W       = 1
) ();
    logic [TDATA_BYTES*8-1:0] tdata;
    logic [TDATA_BYTES-1:0]   tstrb;
    logic [TDATA_BYTES-1:0]   tkeep;
    logic                     tlast;
    logic [TUSER_W-1:0]       tuser;
    logic [TDEST_W-1:0]       tdest;
    logic [TID_W-1:0]         tid;
    logic                     tvalid;
    logic                     tready;

    modport rx (
        input  tdata, tstrb, tkeep, tlast, tuser, tdest, tid, tvalid,
        output tready
    );

    modport tx (
        output tdata, tstrb, tkeep, tlast, tuser, tdest, tid, tvalid,
        input  tready
    );
endinterface

// File: rtl/logic_axi4_stream_timer_counter.sv
// rtl/logic_axi4_stream_timer_counter.sv - load/decrement counter with reload register and expiry pulse
module logic_axi4_stream_timer_counter #(
    parameter int W        = 32,
    parameter int PERIODIC = 0
) (
    input  logic         aclk,
    input  logic         areset_n,
    input  logic         load,
    input  logic [W-1:0] load_value,
    input  logic         enable,
    output logic         expire
);
    localparam logic [W-1:0] ONE = W'(1);

    logic [W-1:0] count_q;
    logic [W-1:0] reload_q;

    // A load in the same cycle masks expiry so a fresh interval always wins
    assign expire = enable && !load && (count_q == ONE);

    // Load, reload-on-expiry or decrement; never steps below 1
    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            count_q  <= '0;
            reload_q <= '0;
        end else if (load) begin
            count_q  <= load_value;
            reload_q <= load_value;
        end else if (expire) begin
            if (PERIODIC != 0) begin
                count_q <= reload_q;
            end
        end else if (enable && (count_q > ONE)) begin
            count_q <= count_q - ONE;
        end
    end
endmodule

// File: rtl/logic_axi4_stream_timer.sv
// rtl/logic_axi4_stream_timer.sv - programmable one-shot/periodic countdown timer with stream event output
module logic_axi4_stream_timer
    import logic_axi4_stream_timer_pkg::*;
#(
    parameter int TDATA_BYTES = 4,
    parameter int PERIODIC    = 0
) (
    input  logic                 aclk,
    input  logic                 areset_n,
    logic_axi4_stream_if.rx      timer_config,
    logic_axi4_stream_if.tx      timer,
    output logic                 busy
);
    localparam int           W           = TDATA_BYTES * 8;
    localparam bit           IS_PERIODIC = (PERIODIC != 0);
    localparam logic [W-1:0] ONE         = W'(1);

    generate
        if (TDATA_BYTES < 1) begin : g_bad_bytes
            $error("logic_axi4_stream_timer: TDATA_BYTES must be >= 1");
        end
        if (PERIODIC != 0 && PERIODIC != 1) begin : g_bad_periodic
            $error("logic_axi4_stream_timer: PERIODIC must be 0 or 1");
        end
    endgenerate

    timer_state_e state_q;
    logic         tvalid_q;
    logic         overrun_q;
    logic         cfg_ready_q;
    logic         accept;
    logic         handshake;
    logic         expire;
    logic         count_en;
    logic [W-1:0] cfg_n;
    logic [W-1:0] load_value;
    logic [W-1:0] tdata_w;
    logic         cfg_unused;

    assign accept     = timer_config.tvalid && cfg_ready_q;
    assign handshake  = tvalid_q && timer.tready;
    assign cfg_n      = timer_config.tdata[W-1:0];
    assign load_value = (cfg_n == '0) ? ONE : cfg_n;
    assign count_en   = (state_q == RUN) || (IS_PERIODIC && state_q == PENDING);
    assign busy       = count_en;

    // Sideband fields of the config stream carry no meaning for the timer
    assign cfg_unused = ^{timer_config.tstrb, timer_config.tkeep, timer_config.tlast,
                          timer_config.tuser, timer_config.tdest, timer_config.tid};

    // Event payload: only the overrun flag is ever non-zero
    always_comb begin
        tdata_w              = '0;
        tdata_w[OVERRUN_BIT] = overrun_q;
    end

    assign timer_config.tready = cfg_ready_q;
    assign timer.tvalid        = tvalid_q;
    assign timer.tdata         = tdata_w;
    assign timer.tlast         = 1'b1;
    assign timer.tstrb         = '1;
    assign timer.tkeep         = '1;
    assign timer.tuser         = '0;
    assign timer.tdest         = '0;
    assign timer.tid           = '0;

    logic_axi4_stream_timer_counter #(
        .W        (W),
        .PERIODIC (PERIODIC)
    ) u_counter (
        .aclk       (aclk),
        .areset_n   (areset_n),
        .load       (accept),
        .load_value (load_value),
        .enable     (count_en),
        .expire     (expire)
    );

    // Control FSM: config accept preempts everything, expiry raises/coalesces the event
    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            state_q     <= IDLE;
            tvalid_q    <= 1'b0;
            overrun_q   <= 1'b0;
            cfg_ready_q <= 1'b0;
        end else begin
            cfg_ready_q <= 1'b1;
            if (accept) begin
                state_q   <= RUN;
                tvalid_q  <= 1'b0;
                overrun_q <= 1'b0;
            end else begin
                case (state_q)
                    RUN: begin
                        if (expire) begin
                            tvalid_q  <= 1'b1;
                            overrun_q <= 1'b0;
                            state_q   <= PENDING;
                        end
                    end
                    PENDING: begin
                        if (handshake) begin
                            overrun_q <= 1'b0;
                            if (expire) begin
                                tvalid_q <= 1'b1;
                            end else begin
                                tvalid_q <= 1'b0;
                                state_q  <= IS_PERIODIC ? RUN : IDLE;
                            end
                        end else if (expire) begin
                            overrun_q <= 1'b1;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_logic_axi4_stream_timer.sv
// tb/tb_logic_axi4_stream_timer.sv - scoreboard bench for one-shot and periodic timer instances
module tb_logic_axi4_stream_timer;

    logic        aclk = 1'b0;
    logic        areset_n = 1'b0;
    logic        cfg_tvalid = 1'b0;
    logic [31:0] cfg_tdata = '0;
    logic        t_tready = 1'b1;
    logic        busy0, busy1;

    int    checks = 0;
    int    errors = 0;
    longint cyc = 0;

    typedef struct {
        longint      edge_no;
        logic [31:0] data;
    } ev_t;

    ev_t sbq0[$];
    ev_t sbq1[$];

    bit     m_valid[2];
    bit     m_ovr[2];
    bit     m_active[2];
    bit     m_rdy[2];
    longint m_next[2];
    longint m_period[2];

    always #5 aclk = ~aclk;

    logic_axi4_stream_if #(.TDATA_BYTES(4)) cfg0 ();
    logic_axi4_stream_if #(.TDATA_BYTES(4)) tmr0 ();
    logic_axi4_stream_if #(.TDATA_BYTES(4)) cfg1 ();
    logic_axi4_stream_if #(.TDATA_BYTES(4)) tmr1 ();

    assign cfg0.tvalid = cfg_tvalid;
    assign cfg0.tdata  = cfg_tdata;
    assign cfg0.tstrb  = 4'h5;
    assign cfg0.tkeep  = 4'h3;
    assign cfg0.tlast  = 1'b0;
    assign cfg0.tuser  = 1'b1;
    assign cfg0.tdest  = 1'b1;
    assign cfg0.tid    = 1'b0;
    assign cfg1.tvalid = cfg_tvalid;
    assign cfg1.tdata  = cfg_tdata;
    assign cfg1.tstrb  = 4'ha;
    assign cfg1.tkeep  = 4'hc;
    assign cfg1.tlast  = 1'b1;
    assign cfg1.tuser  = 1'b0;
    assign cfg1.tdest  = 1'b0;
    assign cfg1.tid    = 1'b1;
    assign tmr0.tready = t_tready;
    assign tmr1.tready = t_tready;

    logic_axi4_stream_timer #(.TDATA_BYTES(4), .PERIODIC(0)) dut0 (
        .aclk         (aclk),
        .areset_n     (areset_n),
        .timer_config (cfg0),
        .timer        (tmr0),
        .busy         (busy0)
    );

    logic_axi4_stream_timer #(.TDATA_BYTES(4), .PERIODIC(1)) dut1 (
        .aclk         (aclk),
        .areset_n     (areset_n),
        .timer_config (cfg1),
        .timer        (tmr1),
        .busy         (busy1)
    );

    task automatic chk(input string name, input int d, input longint got, input longint exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s dut%0d cycle %0d: got %0h expected %0h", name, d, cyc, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_valid[d]  = 1'b0;
            m_ovr[d]    = 1'b0;
            m_active[d] = 1'b0;
            m_rdy[d]    = 1'b0;
            m_next[d]   = 0;
            m_period[d] = 0;
        end
    endtask

    // Absolute-time model: an accepted N schedules expiry at accept_edge + max(N,1)
    task automatic model_step(input int d, input bit per, input bit cv, input logic [31:0] cd,
                              input bit tr, input longint e);
        bit   acc, hs, ex;
        ev_t  ev;
        acc = cv && m_rdy[d];
        hs  = m_valid[d] && tr;
        ex  = m_active[d] && (e == m_next[d]);
        if (hs) begin
            ev.edge_no = e;
            ev.data    = {31'd0, m_ovr[d]};
            if (d == 0) sbq0.push_back(ev);
            else        sbq1.push_back(ev);
        end
        m_rdy[d] = 1'b1;
        if (acc) begin
            m_period[d] = (cd == 0) ? 1 : longint'(cd);
            m_next[d]   = e + m_period[d];
            m_active[d] = 1'b1;
            m_valid[d]  = 1'b0;
            m_ovr[d]    = 1'b0;
        end else if (ex) begin
            if (per) m_next[d] = e + m_period[d];
            else     m_active[d] = 1'b0;
            if (!m_valid[d] || hs) begin
                m_valid[d] = 1'b1;
                m_ovr[d]   = 1'b0;
            end else begin
                m_ovr[d] = 1'b1;
            end
        end else if (hs) begin
            m_valid[d] = 1'b0;
            m_ovr[d]   = 1'b0;
        end
    endtask

    task automatic check_outputs(input int d, input logic tv, input logic [31:0] td, input logic tl,
                                 input logic [3:0] tk, input logic bz, input logic cr);
        chk("tvalid", d, tv, m_valid[d]);
        chk("tdata", d, td, {31'd0, m_ovr[d]});
        chk("busy", d, bz, m_active[d]);
        chk("cfg_tready", d, cr, m_rdy[d]);
        if (tv) begin
            chk("tlast", d, tl, 1);
            chk("tkeep", d, tk, 4'hf);
        end
    endtask

    task automatic pop_check(input int d, input logic [31:0] td);
        ev_t ev;
        if ((d == 0 && sbq0.size() == 0) || (d == 1 && sbq1.size() == 0)) begin
            checks++;
            errors++;
            $display("FAIL event_unexpected dut%0d cycle %0d: got beat %0h expected none", d, cyc, td);
        end else begin
            ev = (d == 0) ? sbq0.pop_front() : sbq1.pop_front();
            chk("event_edge", d, cyc, ev.edge_no);
            chk("event_data", d, td, ev.data);
        end
    endtask

    // Monitor: compare away from the active edge, advance the model, then drain the scoreboard
    always @(negedge aclk) begin
        cyc++;
        if (!areset_n) model_reset();
        check_outputs(0, tmr0.tvalid, tmr0.tdata, tmr0.tlast, tmr0.tkeep, busy0, cfg0.tready);
        check_outputs(1, tmr1.tvalid, tmr1.tdata, tmr1.tlast, tmr1.tkeep, busy1, cfg1.tready);
        if (areset_n) begin
            model_step(0, 1'b0, cfg_tvalid, cfg_tdata, t_tready, cyc);
            model_step(1, 1'b1, cfg_tvalid, cfg_tdata, t_tready, cyc);
        end
        if (tmr0.tvalid && t_tready) pop_check(0, tmr0.tdata);
        if (tmr1.tvalid && t_tready) pop_check(1, tmr1.tdata);
    end

    task automatic cycles(input int n);
        repeat (n) @(posedge aclk);
        #1;
    endtask

    task automatic send_cfg(input logic [31:0] n);
        cfg_tvalid = 1'b1;
        cfg_tdata  = n;
        cycles(1);
        cfg_tvalid = 1'b0;
    endtask

    initial begin
        model_reset();
        cycles(5);
        areset_n = 1'b1;
        cycles(4);
        send_cfg(5);
        cycles(10);
        send_cfg(0);
        cycles(5);
        send_cfg(1);
        cycles(5);
        send_cfg(1000000);
        cycles(499);
        send_cfg(2);
        cycles(10);
        t_tready = 1'b0;
        send_cfg(3);
        cycles(25);
        t_tready = 1'b1;
        cycles(3);
        t_tready = 1'b0;
        send_cfg(4);
        cycles(9);
        t_tready = 1'b1;
        cycles(12);
        for (int i = 0; i < 400; i++) begin
            cfg_tvalid = ($urandom_range(0, 9) == 0);
            cfg_tdata  = $urandom_range(0, 12);
            t_tready   = ($urandom_range(0, 9) < 7);
            cycles(1);
        end
        cfg_tvalid = 1'b0;
        t_tready   = 1'b1;
        cycles(3);
        send_cfg(3);
        cycles(2);
        cfg_tvalid = 1'b1;
        cfg_tdata  = 2;
        cycles(1);
        cfg_tvalid = 1'b0;
        areset_n   = 1'b0;
        cycles(2);
        areset_n = 1'b1;
        cycles(10);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
